// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module : alu_pkg
//  Brief  : ALU control codes, opcode/funct7 constants and FSM state type
//           shared by the decode/execute stage.
//  Rev    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] CTRL_ADD     = 4'h0;
    localparam logic [3:0] CTRL_SUB     = 4'h1;
    localparam logic [3:0] CTRL_OR      = 4'h2;
    localparam logic [3:0] CTRL_AND     = 4'h3;
    localparam logic [3:0] CTRL_XOR     = 4'h4;
    localparam logic [3:0] CTRL_SLL     = 4'h5;
    localparam logic [3:0] CTRL_SRL     = 4'h6;
    localparam logic [3:0] CTRL_SRA     = 4'h7;
    localparam logic [3:0] CTRL_SLT     = 4'h8;
    localparam logic [3:0] CTRL_SLTU    = 4'h9;
    localparam logic [3:0] CTRL_MUL     = 4'hA;
    localparam logic [3:0] CTRL_MULH    = 4'hB;
    localparam logic [3:0] CTRL_MULHSU  = 4'hC;
    localparam logic [3:0] CTRL_MULHU   = 4'hD;
    localparam logic [3:0] CTRL_ILLEGAL = 4'hF;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
//  Module : mul_iter
//  Brief  : Iterative unsigned XLEN x XLEN shift-add multiplier, one
//           multiplier bit per cycle, 2*XLEN product.
//  Rev    : 1.0  initial release
// ============================================================================
module mul_iter #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic                busy,
    output logic                done,
    output logic [2*XLEN-1:0]   product
);

    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] r_mcand;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_mplier;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic [2*XLEN-1:0] w_addend;

    // product is the accumulator after the current step; it is final while done is high
    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign product  = r_acc + w_addend;
    assign done     = r_busy && (r_cnt == CW'(XLEN-1));
    assign busy     = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start && !r_busy) begin
            r_mcand  <= {{XLEN{1'b0}}, a};
            r_acc    <= '0;
            r_mplier <= b;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= product;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_decode_exec.sv
`default_nettype none
// ============================================================================
//  Module : alu_decode_exec
//  Brief  : Execute stage: decodes ALUop/op/funct3/funct7 into a 4-bit ALU
//           control, executes RV32I ALU ops and optional iterative RV32M MUL.
//  Rev    : 1.0  initial release
// ============================================================================
module alu_decode_exec
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int HAS_MUL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [3:0]      alu_ctrl,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    state_t             r_state;
    logic               r_out_valid;
    logic [XLEN-1:0]    r_result;
    logic               r_zero;
    logic [3:0]         r_alu_ctrl;
    logic               r_illegal;
    logic               r_neg;
    logic [3:0]         r_mctrl;

    logic [3:0]         w_ctrl;
    logic               w_is_mul;
    logic               w_accept;
    logic [XLEN-1:0]    w_alu_res;
    logic [SHW-1:0]     w_shamt;
    logic               w_a_sgn;
    logic               w_b_sgn;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*XLEN-1:0]  w_prod;
    logic [2*XLEN-1:0]  w_full;
    logic [XLEN-1:0]    w_mul_res;

    always_comb begin
        w_ctrl = CTRL_ILLEGAL;
        case (alu_op)
            2'b00: w_ctrl = CTRL_ADD;
            2'b01: w_ctrl = CTRL_SUB;
            2'b10: begin
                if (op == OP_R && funct7 == F7_MULDIV) begin
                    if (HAS_MUL != 0 && !funct3[2]) begin
                        w_ctrl = CTRL_MUL + {2'b00, funct3[1:0]};
                    end
                end else if (op == OP_R && funct7 != F7_BASE && funct7 != F7_ALT) begin
                    w_ctrl = CTRL_ILLEGAL;
                end else begin
                    case (funct3)
                        3'b000: w_ctrl = (op == OP_R && funct7 == F7_ALT) ? CTRL_SUB : CTRL_ADD;
                        3'b001: w_ctrl = CTRL_SLL;
                        3'b010: w_ctrl = CTRL_SLT;
                        3'b011: w_ctrl = CTRL_SLTU;
                        3'b100: w_ctrl = CTRL_XOR;
                        3'b101: w_ctrl = funct7[5] ? CTRL_SRA : CTRL_SRL;
                        3'b110: w_ctrl = CTRL_OR;
                        default: w_ctrl = CTRL_AND;
                    endcase
                end
            end
            default: w_ctrl = CTRL_ILLEGAL;
        endcase
    end

    assign w_is_mul = (w_ctrl >= CTRL_MUL) && (w_ctrl <= CTRL_MULHU);
    assign w_shamt  = src_b[SHW-1:0];

    // Single-cycle datapath; multiply and illegal codes yield 0 here
    always_comb begin
        w_alu_res = '0;
        case (w_ctrl)
            CTRL_ADD:  w_alu_res = src_a + src_b;
            CTRL_SUB:  w_alu_res = src_a - src_b;
            CTRL_OR:   w_alu_res = src_a | src_b;
            CTRL_AND:  w_alu_res = src_a & src_b;
            CTRL_XOR:  w_alu_res = src_a ^ src_b;
            CTRL_SLL:  w_alu_res = src_a << w_shamt;
            CTRL_SRL:  w_alu_res = src_a >> w_shamt;
            CTRL_SRA:  w_alu_res = $signed(src_a) >>> w_shamt;
            CTRL_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            CTRL_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            default:   w_alu_res = '0;
        endcase
    end

    // Multiply magnitudes; the sign is reapplied to the full 2*XLEN product
    assign w_a_sgn = (w_ctrl == CTRL_MULH || w_ctrl == CTRL_MULHSU) && src_a[XLEN-1];
    assign w_b_sgn = (w_ctrl == CTRL_MULH) && src_b[XLEN-1];
    assign w_mag_a = w_a_sgn ? (~src_a + 1'b1) : src_a;
    assign w_mag_b = w_b_sgn ? (~src_b + 1'b1) : src_b;

    generate
        if (HAS_MUL != 0) begin : g_mul
            mul_iter #(
                .XLEN    (XLEN)
            ) u_mul (
                .clk     (clk),
                .rst     (rst),
                .start   (w_accept && w_is_mul),
                .a       (w_mag_a),
                .b       (w_mag_b),
                .busy    (w_mul_busy),
                .done    (w_mul_done),
                .product (w_prod)
            );
        end else begin : g_no_mul
            assign w_mul_busy = 1'b0;
            assign w_mul_done = 1'b0;
            assign w_prod     = '0;
        end
    endgenerate

    assign w_full    = r_neg ? (~w_prod + 1'b1) : w_prod;
    assign w_mul_res = (r_mctrl == CTRL_MUL) ? w_full[XLEN-1:0] : w_full[2*XLEN-1:XLEN];

    assign in_ready = !rst && !w_mul_busy &&
                      ((r_state == ST_IDLE) || (r_state == ST_DONE && out_ready));
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_alu_ctrl  <= CTRL_ADD;
            r_illegal   <= 1'b0;
            r_neg       <= 1'b0;
            r_mctrl     <= CTRL_ADD;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_state     <= ST_MUL;
                r_out_valid <= 1'b0;
                r_neg       <= w_a_sgn ^ w_b_sgn;
                r_mctrl     <= w_ctrl;
            end else begin
                r_state     <= ST_DONE;
                r_out_valid <= 1'b1;
                r_result    <= w_alu_res;
                r_zero      <= (w_alu_res == '0);
                r_alu_ctrl  <= w_ctrl;
                r_illegal   <= (w_ctrl == CTRL_ILLEGAL);
            end
        end else if (r_state == ST_MUL && w_mul_done) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_mul_res;
            r_zero      <= (w_mul_res == '0);
            r_alu_ctrl  <= r_mctrl;
            r_illegal   <= 1'b0;
        end else if (r_state == ST_DONE && out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign alu_ctrl  = r_alu_ctrl;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_decode_exec.sv
`default_nettype none
// ============================================================================
//  Module : tb_alu_decode_exec
//  Brief  : Directed vector bench for alu_decode_exec (XLEN=32), with a
//           second HAS_MUL=0 instance sharing the input side.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_alu_decode_exec;

    localparam logic [6:0] R = 7'b0110011;
    localparam logic [6:0] I = 7'b0010011;

    typedef struct {
        logic [1:0]  aop;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  ctrl;
        logic        ill;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic [3:0]  alu_ctrl;
    logic        illegal;

    logic        nm_in_ready;
    logic        nm_out_valid;
    logic [31:0] nm_result;
    logic        nm_zero;
    logic [3:0]  nm_alu_ctrl;
    logic        nm_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_decode_exec #(.XLEN(32), .HAS_MUL(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .op(op), .funct3(funct3), .funct7(funct7),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .alu_ctrl(alu_ctrl), .illegal(illegal)
    );

    alu_decode_exec #(.XLEN(32), .HAS_MUL(0)) dut_nomul (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nm_in_ready),
        .alu_op(alu_op), .op(op), .funct3(funct3), .funct7(funct7),
        .src_a(src_a), .src_b(src_b), .out_valid(nm_out_valid), .out_ready(out_ready),
        .result(nm_result), .zero(nm_zero), .alu_ctrl(nm_alu_ctrl), .illegal(nm_illegal)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] aop, input logic [6:0] o, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic [3:0] ctrl, input logic ill,
                                input int lat);
        vec_t v;
        v.aop = aop; v.op = o; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b;
        v.res = res; v.ctrl = ctrl; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    // Present v, wait for acceptance, then count cycles until out_valid.
    task automatic send(input vec_t v, output int lat, output logic rdy_seen,
                        output logic nm_ill, output logic [3:0] nm_ctrl, output logic [31:0] nm_res);
        int n;
        @(negedge clk);
        alu_op = v.aop; op = v.op; funct3 = v.f3; funct7 = v.f7;
        src_a = v.a; src_b = v.b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678; alu_op = 2'b11;
        nm_ill = nm_illegal; nm_ctrl = nm_alu_ctrl; nm_res = nm_result;
        rdy_seen = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    vec_t        vt[$];
    int          lat;
    logic        rdy_seen;
    logic        nm_ill;
    logic [3:0]  nm_ctrl;
    logic [31:0] nm_res;
    int          cnt;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; op = R; funct3 = 3'b000; funct7 = 7'b0;
        src_a = '0; src_b = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_during_rst", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_zero",      64'(zero),      64'd0);
        chk("rst_alu_ctrl",  64'(alu_ctrl),  64'd0);
        chk("rst_illegal",   64'(illegal),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        vt.push_back(mk(2'b10, R, 3'b000, 7'h00, 32'd5,        32'd7,        32'd12,       4'h0, 1'b0, 1));
        vt.push_back(mk(2'b01, R, 3'b000, 7'h00, 32'd9,        32'd9,        32'd0,        4'h1, 1'b0, 1));
        vt.push_back(mk(2'b10, I, 3'b000, 7'h20, 32'd10,       32'd3,        32'd13,       4'h0, 1'b0, 1));
        vt.push_back(mk(2'b10, R, 3'b000, 7'h20, 32'd3,        32'd5,        32'hFFFFFFFE, 4'h1, 1'b0, 1));
        vt.push_back(mk(2'b10, R, 3'b101, 7'h20, 32'h80000000, 32'd4,        32'hF8000000, 4'h7, 1'b0, 1));
        vt.push_back(mk(2'b10, R, 3'b101, 7'h00, 32'h80000000, 32'd4,        32'h08000000, 4'h6, 1'b0, 1));
        vt.push_back(mk(2'b10, I, 3'b101, 7'h20, 32'h80000000, 32'h00000404, 32'hF8000000, 4'h7, 1'b0, 1));
        vt.push_back(mk(2'b10, R, 3'b001, 7'h00, 32'd1,        32'd31,       32'h80000000, 4'h5, 1'b0, 1));
        vt.push_back(mk(2'b10, R, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1,        4'h8, 1'b0, 1));
        vt.push_back(mk(2'b10, R, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        4'h9, 1'b0, 1));
        vt.push_back(mk(2'b10, R, 3'b100, 7'h00, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 4'h4, 1'b0, 1));
        vt.push_back(mk(2'b10, R, 3'b110, 7'h00, 32'h000000F0, 32'h0000000F, 32'h000000FF, 4'h2, 1'b0, 1));
        vt.push_back(mk(2'b10, R, 3'b111, 7'h00, 32'h000000F0, 32'h0000003C, 32'h00000030, 4'h3, 1'b0, 1));
        vt.push_back(mk(2'b10, R, 3'b000, 7'h01, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 4'hA, 1'b0, 33));
        vt.push_back(mk(2'b10, R, 3'b001, 7'h01, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 4'hB, 1'b0, 33));
        vt.push_back(mk(2'b10, R, 3'b010, 7'h01, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 4'hC, 1'b0, 33));
        vt.push_back(mk(2'b10, R, 3'b011, 7'h01, 32'hFFFFFFFE, 32'd3,        32'h00000002, 4'hD, 1'b0, 33));
        vt.push_back(mk(2'b10, R, 3'b001, 7'h01, 32'h80000000, 32'h80000000, 32'h40000000, 4'hB, 1'b0, 33));
        vt.push_back(mk(2'b10, R, 3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'hD, 1'b0, 33));
        vt.push_back(mk(2'b10, R, 3'b000, 7'h01, 32'd0,        32'd5,        32'd0,        4'hA, 1'b0, 33));
        vt.push_back(mk(2'b11, R, 3'b000, 7'h00, 32'd5,        32'd7,        32'd0,        4'hF, 1'b1, 1));
        vt.push_back(mk(2'b10, R, 3'b100, 7'h01, 32'd8,        32'd2,        32'd0,        4'hF, 1'b1, 1));
        vt.push_back(mk(2'b10, R, 3'b000, 7'h02, 32'd8,        32'd2,        32'd0,        4'hF, 1'b1, 1));

        foreach (vt[i]) begin
            send(vt[i], lat, rdy_seen, nm_ill, nm_ctrl, nm_res);
            chk($sformatf("v%0d_latency", i),  64'(lat),       64'(vt[i].lat));
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_result", i),   64'(result),    64'(vt[i].res));
            chk($sformatf("v%0d_zero", i),     64'(zero),      64'(vt[i].res == 32'd0));
            chk($sformatf("v%0d_alu_ctrl", i), 64'(alu_ctrl),  64'(vt[i].ctrl));
            chk($sformatf("v%0d_illegal", i),  64'(illegal),   64'(vt[i].ill));
            if (vt[i].lat > 1) begin
                chk($sformatf("v%0d_in_ready_in_mul", i), 64'(rdy_seen), 64'd0);
                chk($sformatf("v%0d_nomul_illegal", i), 64'(nm_ill),  64'd1);
                chk($sformatf("v%0d_nomul_ctrl", i),    64'(nm_ctrl), 64'hF);
                chk($sformatf("v%0d_nomul_result", i),  64'(nm_res),  64'd0);
            end
        end

        // Back-to-back single-cycle ops
        @(negedge clk);
        alu_op = 2'b00; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_0_result", 64'(result), 64'd2);
        @(negedge clk);
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        alu_op = 2'b01; src_a = 32'd20; src_b = 32'd5;
        @(posedge clk); #1;
        chk("b2b_1_result", 64'(result), 64'd15);
        chk("b2b_1_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        alu_op = 2'b10; op = R; funct3 = 3'b111; funct7 = 7'h00; src_a = 32'd6; src_b = 32'd3;
        @(posedge clk); #1;
        chk("b2b_2_result", 64'(result), 64'd2);
        chk("b2b_2_ctrl", 64'(alu_ctrl), 64'd3);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_drain", 64'(out_valid), 64'd0);

        // Output stall: result held, no new accept, exactly one transfer on release
        @(negedge clk);
        out_ready = 1'b0; alu_op = 2'b00; src_a = 32'd1; src_b = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        alu_op = 2'b01; src_a = 32'd99;
        chk("stall_valid0", 64'(out_valid), 64'd1);
        chk("stall_result0", 64'(result), 64'd3);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_valid", k),    64'(out_valid), 64'd1);
            chk($sformatf("stall%0d_result", k),   64'(result),    64'd3);
            chk($sformatf("stall%0d_in_ready", k), 64'(in_ready),  64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        chk("stall_single_transfer", 64'(cnt), 64'd0);

        // Reset partway through a multiply
        @(negedge clk);
        alu_op = 2'b10; op = R; funct3 = 3'b000; funct7 = 7'h01;
        src_a = 32'd7; src_b = 32'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmul_valid_in_rst", 64'(out_valid), 64'd0);
        chk("rstmul_ready_in_rst", 64'(in_ready),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmul_ready_after", 64'(in_ready), 64'd1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        chk("rstmul_no_valid", 64'(cnt), 64'd0);

        send(mk(2'b00, R, 3'b000, 7'h00, 32'd40, 32'd2, 32'd42, 4'h0, 1'b0, 1),
             lat, rdy_seen, nm_ill, nm_ctrl, nm_res);
        chk("post_rst_latency", 64'(lat), 64'd1);
        chk("post_rst_result", 64'(result), 64'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
